mprj_pad_cfg_loader: RTL and testbench

Parametrised serial configuration loader for the user-project pad ring. On a start request it snapshots a flat vector of per-pad configuration words and shifts them, MSB first, into the daisy-chained pad control blocks. It then pulses a load strobe so every pad latches its word at the same time. It sits between the housekeeping register bank and the `mprj_io` pad array, and replaces static per-pad wiring with one programmable chain of any width.

---
 rtl/mprj_pad_cfg_loader.sv | 123 ++++++++++++
 tb/tb_mprj_pad_cfg_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mprj_pad_cfg_loader.sv
// Serial configuration loader for the user-project pad ring: snapshots the per-pad
// configuration vector, shifts it MSB first into the pad chain, then strobes a common load.
module mprj_pad_cfg_loader #(
    parameter int NPADS    = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                      clock,
    input  logic                      resetb,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NPADS*CFG_BITS-1:0] cfg_data,
    output logic                      busy,
    output logic                      done,
    output logic                      serial_clock,
    output logic                      serial_data,
    output logic                      serial_load,
    output logic [2:0]                fsm_state
);

    localparam int TOTAL = NPADS * CFG_BITS;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int PW    = $clog2(CLK_DIV + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT_LO = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_LOAD     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic [BW-1:0] BIT_TOTAL  = BW'(TOTAL);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

    logic [2:0]       state;
    logic [PW-1:0]    phase;
    logic [BW-1:0]    bit_cnt;
    logic [TOTAL-1:0] shadow;
    logic [TOTAL-1:0] shadow_shl;

    // Shift through a full-width temporary so a single-bit chain needs no special case.
    assign shadow_shl = shadow << 1;
    assign fsm_state  = state;

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state        <= ST_IDLE;
            phase        <= '0;
            bit_cnt      <= '0;
            shadow       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        shadow       <= cfg_data;
                        bit_cnt      <= BIT_TOTAL;
                        serial_data  <= cfg_data[TOTAL-1];
                        serial_clock <= 1'b0;
                        phase        <= '0;
                        busy         <= 1'b1;
                        state        <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO, ST_SHIFT_HI: begin
                    if (abort) begin
                        state        <= ST_IDLE;
                        phase        <= '0;
                        busy         <= 1'b0;
                        serial_clock <= 1'b0;
                        serial_load  <= 1'b0;
                        serial_data  <= 1'b0;
                    end else if (phase != PHASE_LAST) begin
                        phase <= phase + PW'(1);
                    end else if (state == ST_SHIFT_LO) begin
                        phase        <= '0;
                        serial_clock <= 1'b1;
                        state        <= ST_SHIFT_HI;
                    end else begin
                        // End of a high phase: one bit has been clocked into the chain.
                        phase        <= '0;
                        serial_clock <= 1'b0;
                        bit_cnt      <= bit_cnt - BW'(1);
                        if (bit_cnt == BW'(1)) begin
                            serial_load <= 1'b1;
                            state       <= ST_LOAD;
                        end else begin
                            shadow      <= shadow_shl;
                            serial_data <= shadow_shl[TOTAL-1];
                            state       <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_LOAD: begin
                    if (phase != PHASE_LAST) begin
                        phase <= phase + PW'(1);
                    end else begin
                        phase       <= '0;
                        serial_load <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    phase        <= '0;
                    busy         <= 1'b0;
                    serial_clock <= 1'b0;
                    serial_load  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mprj_pad_cfg_loader.sv
// Directed bench for mprj_pad_cfg_loader: small chains (CLK_DIV 1 and 3) plus the
// default 38x13 chain checked against a behavioural pad-chain model.
module tb_mprj_pad_cfg_loader;

    localparam int TOT_C = 38 * 13;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             resetb, start, abort, sel;
    logic [7:0]       cfg;
    logic             start_c;
    logic [TOT_C-1:0] cfg_c;

    logic       busy_a, done_a, sclk_a, sdata_a, sload_a;
    logic [2:0] st_a;
    logic       busy_b, done_b, sclk_b, sdata_b, sload_b;
    logic [2:0] st_b;
    logic       busy_c, done_c, sclk_c, sdata_c, sload_c;
    logic [2:0] st_c;

    int total = 0;
    int bad   = 0;

    mprj_pad_cfg_loader #(.NPADS(2), .CFG_BITS(4), .CLK_DIV(1)) dut_a (
        .clock(clock), .resetb(resetb), .start(start & ~sel), .abort(abort & ~sel),
        .cfg_data(cfg), .busy(busy_a), .done(done_a), .serial_clock(sclk_a),
        .serial_data(sdata_a), .serial_load(sload_a), .fsm_state(st_a)
    );

    mprj_pad_cfg_loader #(.NPADS(2), .CFG_BITS(4), .CLK_DIV(3)) dut_b (
        .clock(clock), .resetb(resetb), .start(start & sel), .abort(abort & sel),
        .cfg_data(cfg), .busy(busy_b), .done(done_b), .serial_clock(sclk_b),
        .serial_data(sdata_b), .serial_load(sload_b), .fsm_state(st_b)
    );

    mprj_pad_cfg_loader dut_c (
        .clock(clock), .resetb(resetb), .start(start_c), .abort(1'b0),
        .cfg_data(cfg_c), .busy(busy_c), .done(done_c), .serial_clock(sclk_c),
        .serial_data(sdata_c), .serial_load(sload_c), .fsm_state(st_c)
    );

    wire s_busy  = sel ? busy_b  : busy_a;
    wire s_done  = sel ? done_b  : done_a;
    wire s_sclk  = sel ? sclk_b  : sclk_a;
    wire s_sdata = sel ? sdata_b : sdata_a;
    wire s_sload = sel ? sload_b : sload_a;

    // Pad chain model: bits enter pad 0's LSB and ripple toward pad NPADS-1.
    logic [TOT_C-1:0] chain   = '0;
    logic [TOT_C-1:0] latched = '0;
    always @(posedge sclk_c) chain <= {chain[TOT_C-2:0], sdata_c};
    always @(posedge sload_c) latched <= chain;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start, then observes win cycles; cycle c is the c-th cycle after the start edge.
    task automatic run_small(input int win, input int poke_cyc, input int abort_cyc,
                             output int busy_n, output int load_n, output int load_last,
                             output int done_n, output int done_last, output int hi_n,
                             output logic [7:0] bits, output int nbits);
        logic prev_sclk;
        busy_n = 0; load_n = 0; load_last = 0; done_n = 0; done_last = 0;
        hi_n = 0; bits = '0; nbits = 0; prev_sclk = 1'b0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= win; c++) begin
            start = 1'b0;
            abort = 1'b0;
            if (s_busy) busy_n++;
            if (s_sclk) hi_n++;
            if (s_sclk && !prev_sclk) begin
                bits  = {bits[6:0], s_sdata};
                nbits++;
            end
            prev_sclk = s_sclk;
            if (s_sload) begin load_n++; load_last = c; end
            if (s_done)  begin done_n++; done_last = c; end
            if (c == poke_cyc) begin cfg = 8'hFF; start = 1'b1; end
            if (c == abort_cyc) abort = 1'b1;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    int         busy_n, load_n, load_last, done_n, done_last, hi_n, nbits;
    logic [7:0] bits;
    int         stray;

    initial begin
        resetb = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
        cfg = 8'hA5; start_c = 1'b0; cfg_c = '0;
        tick();
        tick();

        // Start pulses during reset must be ignored.
        start = 1'b1;
        tick();
        tick();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_sclk", sclk_a, 0);
        check("rst_sdata", sdata_a, 0);
        check("rst_sload", sload_a, 0);
        check("rst_state", st_a, 0);
        check("rst_busy_c", busy_c, 0);
        start = 1'b0;
        resetb = 1'b1;
        tick();
        check("rst_release_busy", busy_a, 0);

        // Bit order with 8'hA5.
        run_small(25, 0, 0, busy_n, load_n, load_last, done_n, done_last, hi_n, bits, nbits);
        check("a5_busy_len", busy_n, 18);
        check("a5_bits", bits, 8'hA5);
        check("a5_nbits", nbits, 8);
        check("a5_load_len", load_n, 1);
        check("a5_load_at", load_last, 17);
        check("a5_done_n", done_n, 1);
        check("a5_done_at", done_last, 18);
        check("a5_sclk_hi", hi_n, 8);

        // Abort during the third high phase.
        run_small(25, 0, 6, busy_n, load_n, load_last, done_n, done_last, hi_n, bits, nbits);
        check("abort_busy_len", busy_n, 6);
        check("abort_load", load_n, 0);
        check("abort_done", done_n, 0);
        check("abort_bits", bits, 8'h05);
        check("abort_nbits", nbits, 3);
        check("abort_state", st_a, 0);

        // Fresh start after abort.
        run_small(25, 0, 0, busy_n, load_n, load_last, done_n, done_last, hi_n, bits, nbits);
        check("restart_busy_len", busy_n, 18);
        check("restart_bits", bits, 8'hA5);
        check("restart_done_n", done_n, 1);

        // Snapshot: data change and extra start mid-transaction.
        run_small(25, 8, 0, busy_n, load_n, load_last, done_n, done_last, hi_n, bits, nbits);
        check("snap_bits", bits, 8'hA5);
        check("snap_done_n", done_n, 1);
        check("snap_busy_len", busy_n, 18);
        cfg = 8'hA5;

        // Reset in the middle of a shift.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("midrst_busy_pre", busy_a, 1);
        resetb = 1'b0;
        tick();
        check("midrst_busy", busy_a, 0);
        check("midrst_sclk", sclk_a, 0);
        check("midrst_sload", sload_a, 0);
        check("midrst_sdata", sdata_a, 0);
        check("midrst_state", st_a, 0);
        resetb = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            if (sload_a || done_a || busy_a) stray++;
            tick();
        end
        check("midrst_quiet", stray, 0);

        // Divider CLK_DIV=3.
        sel = 1'b1;
        run_small(60, 0, 0, busy_n, load_n, load_last, done_n, done_last, hi_n, bits, nbits);
        check("div3_busy_len", busy_n, 52);
        check("div3_sclk_hi", hi_n, 24);
        check("div3_load_len", load_n, 3);
        check("div3_load_last", load_last, 51);
        check("div3_done_at", done_last, 52);
        check("div3_bits", bits, 8'hA5);
        sel = 1'b0;

        // Default 38x13 chain against the behavioural model.
        for (int i = 0; i < TOT_C; i++) cfg_c[i] = 1'($urandom_range(0, 1));
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        busy_n = 0; done_n = 0; done_last = 0;
        for (int c = 1; c <= 2100; c++) begin
            if (busy_c) busy_n++;
            if (done_c) begin done_n++; done_last = c; end
            tick();
        end
        check("def_busy_len", busy_n, 1979);
        check("def_done_at", done_last, 1979);
        check("def_done_n", done_n, 1);
        total++;
        assert (latched === cfg_c) else begin
            bad++;
            $error("FAIL def_chain observed=%0h expected=%0h", latched[63:0], cfg_c[63:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
